// File: rtl/pc_gen_unit_if.sv
// pc_gen_unit_if: the control inputs and PC/trap/RAS status outputs of pc_gen_unit.
interface pc_gen_unit_if #(
    parameter int unsigned XLEN = 32
);
    logic            load;
    logic [1:0]      pc_sel;
    logic [XLEN-1:0] imm_ext;
    logic [XLEN-1:0] rs1_val;
    logic            is_call;
    logic            is_ret;
    logic [XLEN-1:0] program_counter;
    logic [XLEN-1:0] pc_plus4;
    logic            trap_pulse;
    logic [XLEN-1:0] bad_addr;
    logic [4:0]      ras_count;

    // Sequencing logic drives the controls and observes the PC.
    modport master (
        output load, pc_sel, imm_ext, rs1_val, is_call, is_ret,
        input  program_counter, pc_plus4, trap_pulse, bad_addr, ras_count
    );

    // The PC generator consumes the controls and produces the PC.
    modport slave (
        input  load, pc_sel, imm_ext, rs1_val, is_call, is_ret,
        output program_counter, pc_plus4, trap_pulse, bad_addr, ras_count
    );
endinterface

// File: rtl/pc_gen_unit.sv
// pc_gen_unit: program counter generator with misaligned-target trap handling
// and an optional return-address stack, enabled by defining PC_GEN_RAS_EN.
module pc_gen_unit #(
    parameter int unsigned     XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = '0,
    parameter logic [XLEN-1:0] TRAP_VECTOR  = XLEN'(32'h0000_0100),
    parameter int unsigned     RAS_DEPTH    = 4
) (
    input logic         clk,
    input logic         areset,
    pc_gen_unit_if.slave bus
);
    typedef enum logic {RUN = 1'b0, TRAP = 1'b1} state_t;

    state_t          state;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] bad_addr_q;
    logic [XLEN-1:0] pc_plus4_c;
    logic [XLEN-1:0] jr_sum_c;
    logic [XLEN-1:0] target_c;
    logic            misalign_c;
    logic            ras_pop_c;
    logic [XLEN-1:0] ras_top_c;
    logic [4:0]      ras_cnt;

    assign pc_plus4_c = pc + XLEN'(4);
    assign jr_sum_c   = bus.rs1_val + bus.imm_ext;

`ifdef PC_GEN_RAS_EN
    localparam int unsigned PTR_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;

    // Circular stack: ras_sp is the next free slot, so a push when full
    // lands on the oldest entry.
    logic [XLEN-1:0]  ras_mem [RAS_DEPTH];
    logic [PTR_W-1:0] ras_sp;
    logic             ras_push_c;

    assign ras_top_c  = ras_mem[ras_sp - PTR_W'(1)];
    assign ras_push_c = bus.load && bus.is_call;
    assign ras_pop_c  = bus.load && bus.is_ret && (bus.pc_sel == 2'b10) && (ras_cnt != 5'd0);

    // Push/pop bookkeeping; call together with a valid return replaces the top.
    always_ff @(posedge clk or negedge areset) begin
        if (!areset) begin
            for (int unsigned i = 0; i < RAS_DEPTH; i++) begin
                ras_mem[i] <= '0;
            end
            ras_sp  <= '0;
            ras_cnt <= '0;
        end else if (ras_push_c && ras_pop_c) begin
            ras_mem[ras_sp - PTR_W'(1)] <= pc_plus4_c;
        end else if (ras_push_c) begin
            ras_mem[ras_sp] <= pc_plus4_c;
            ras_sp          <= ras_sp + PTR_W'(1);
            if (ras_cnt != 5'(RAS_DEPTH)) begin
                ras_cnt <= ras_cnt + 5'd1;
            end
        end else if (ras_pop_c) begin
            ras_sp  <= ras_sp - PTR_W'(1);
            ras_cnt <= ras_cnt - 5'd1;
        end
    end
`else
    logic unused_ras_c;

    assign unused_ras_c = ^{bus.is_call, bus.is_ret};
    assign ras_pop_c    = 1'b0;
    assign ras_top_c    = '0;
    assign ras_cnt      = '0;
`endif

    // Next-PC source selection and alignment check.
    always_comb begin
        target_c = pc_plus4_c;
        unique case (bus.pc_sel)
            2'b00: target_c = pc_plus4_c;
            2'b01: target_c = pc + bus.imm_ext;
            2'b10: target_c = (ras_pop_c ? ras_top_c : jr_sum_c) & ~XLEN'(1);
            2'b11: target_c = TRAP_VECTOR;
            default: target_c = pc_plus4_c;
        endcase
        misalign_c = (bus.pc_sel != 2'b11) && (target_c[1:0] != 2'b00);
    end

    // PC register and RUN/TRAP state; TRAP lasts one cycle unless re-entered.
    always_ff @(posedge clk or negedge areset) begin
        if (!areset) begin
            pc         <= RESET_VECTOR;
            bad_addr_q <= '0;
            state      <= RUN;
        end else begin
            state <= RUN;
            if (bus.load) begin
                if (misalign_c) begin
                    pc         <= TRAP_VECTOR;
                    bad_addr_q <= target_c;
                    state      <= TRAP;
                end else begin
                    pc <= target_c;
                end
            end
        end
    end

    assign bus.program_counter = pc;
    assign bus.pc_plus4        = pc_plus4_c;
    assign bus.trap_pulse      = (state == TRAP);
    assign bus.bad_addr        = bad_addr_q;
    assign bus.ras_count       = ras_cnt;
endmodule

// File: tb/tb_pc_gen_unit.sv
// tb_pc_gen_unit: directed checks of pc_gen_unit; RAS checks follow PC_GEN_RAS_EN.
module tb_pc_gen_unit;
    logic clk;
    logic areset;
    int   checks;
    int   errors;

    pc_gen_unit_if #(.XLEN(32)) bus ();

    pc_gen_unit #(
        .XLEN        (32),
        .RESET_VECTOR(32'h0),
        .TRAP_VECTOR (32'h0000_0100),
        .RAS_DEPTH   (4)
    ) dut (
        .clk   (clk),
        .areset(areset),
        .bus   (bus)
    );

    // Free-running clock, 10 time-unit period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, obs, exp);
        end
    endtask

    // Apply one set of controls, then sample 1 unit after the next rising edge.
    task automatic step(input logic ld, input logic [1:0] sel, input logic [31:0] imm,
                        input logic [31:0] rs1, input logic call, input logic ret);
        bus.load    = ld;
        bus.pc_sel  = sel;
        bus.imm_ext = imm;
        bus.rs1_val = rs1;
        bus.is_call = call;
        bus.is_ret  = ret;
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks      = 0;
        errors      = 0;
        areset      = 1'b0;
        bus.load    = 1'b0;
        bus.pc_sel  = 2'b00;
        bus.imm_ext = '0;
        bus.rs1_val = '0;
        bus.is_call = 1'b0;
        bus.is_ret  = 1'b0;

        #3;
        check("rst_pc", bus.program_counter, 32'h0);
        check("rst_trap", 32'(bus.trap_pulse), 32'h0);
        check("rst_bad", bus.bad_addr, 32'h0);
        check("rst_ras", 32'(bus.ras_count), 32'h0);
        check("rst_plus4", bus.pc_plus4, 32'h4);
        #9;
        areset = 1'b1;

        // Sequential fetch, then hold.
        step(1'b1, 2'b00, 32'h0, 32'h0, 1'b0, 1'b0);
        check("seq_pc4", bus.program_counter, 32'h4);
        step(1'b1, 2'b00, 32'h0, 32'h0, 1'b0, 1'b0);
        check("seq_pc8", bus.program_counter, 32'h8);
        step(1'b1, 2'b00, 32'h0, 32'h0, 1'b0, 1'b0);
        check("seq_pc12", bus.program_counter, 32'hC);
        step(1'b0, 2'b01, 32'h40, 32'h0, 1'b0, 1'b0);
        check("hold_pc", bus.program_counter, 32'hC);
        check("hold_plus4", bus.pc_plus4, 32'h10);

        // Negative branch offset and wrap-around.
        step(1'b1, 2'b00, 32'h0, 32'h0, 1'b0, 1'b0);
        check("pc_0x10", bus.program_counter, 32'h10);
        step(1'b1, 2'b01, 32'hFFFF_FFF8, 32'h0, 1'b0, 1'b0);
        check("branch_back", bus.program_counter, 32'h8);
        step(1'b1, 2'b10, 32'h0, 32'hFFFF_FFFC, 1'b0, 1'b0);
        check("jr_top", bus.program_counter, 32'hFFFF_FFFC);
        check("plus4_wrap", bus.pc_plus4, 32'h0);
        step(1'b1, 2'b00, 32'h0, 32'h0, 1'b0, 1'b0);
        check("pc_wrap", bus.program_counter, 32'h0);

        // Misaligned jump-register target traps for one cycle.
        step(1'b1, 2'b10, 32'h0, 32'h203, 1'b0, 1'b0);
        check("mis_pc", bus.program_counter, 32'h100);
        check("mis_bad", bus.bad_addr, 32'h202);
        check("mis_trap", 32'(bus.trap_pulse), 32'h1);
        step(1'b0, 2'b00, 32'h0, 32'h0, 1'b0, 1'b0);
        check("mis_trap_clr", 32'(bus.trap_pulse), 32'h0);
        check("mis_bad_hold", bus.bad_addr, 32'h202);
        check("mis_pc_hold", bus.program_counter, 32'h100);

        // Back-to-back misalignment keeps the trap up and refreshes bad_addr.
        step(1'b1, 2'b01, 32'h2, 32'h0, 1'b0, 1'b0);
        check("b2b1_bad", bus.bad_addr, 32'h102);
        check("b2b1_trap", 32'(bus.trap_pulse), 32'h1);
        step(1'b1, 2'b01, 32'h6, 32'h0, 1'b0, 1'b0);
        check("b2b2_bad", bus.bad_addr, 32'h106);
        check("b2b2_trap", 32'(bus.trap_pulse), 32'h1);
        check("b2b2_pc", bus.program_counter, 32'h100);

        // Direct trap entry: no pulse, bad_addr untouched.
        step(1'b1, 2'b00, 32'h0, 32'h0, 1'b0, 1'b0);
        check("post_trap_pc", bus.program_counter, 32'h104);
        check("post_trap_clr", 32'(bus.trap_pulse), 32'h0);
        step(1'b1, 2'b11, 32'h0, 32'h0, 1'b0, 1'b0);
        check("sel11_pc", bus.program_counter, 32'h100);
        check("sel11_trap", 32'(bus.trap_pulse), 32'h0);
        check("sel11_bad", bus.bad_addr, 32'h106);

        // Jump-register clears bit 0 only; result stays aligned.
        step(1'b1, 2'b10, 32'h0, 32'h301, 1'b0, 1'b0);
        check("jr_lsb_pc", bus.program_counter, 32'h300);
        check("jr_lsb_trap", 32'(bus.trap_pulse), 32'h0);

        // Asynchronous reset in the middle of a TRAP cycle.
        step(1'b1, 2'b01, 32'h1, 32'h0, 1'b0, 1'b0);
        check("pre_rst_trap", 32'(bus.trap_pulse), 32'h1);
        bus.load = 1'b0;
        #2;
        areset = 1'b0;
        #1;
        check("arst_trap", 32'(bus.trap_pulse), 32'h0);
        check("arst_pc", bus.program_counter, 32'h0);
        check("arst_bad", bus.bad_addr, 32'h0);
        #3;
        areset = 1'b1;
        step(1'b1, 2'b00, 32'h0, 32'h0, 1'b0, 1'b0);
        check("post_rst_pc", bus.program_counter, 32'h4);
        check("post_rst_trap", 32'(bus.trap_pulse), 32'h0);

`ifdef PC_GEN_RAS_EN
        // Call at 0x40 then return through the stack.
        step(1'b1, 2'b10, 32'h0, 32'h40, 1'b0, 1'b0);
        check("ras_at40", bus.program_counter, 32'h40);
        step(1'b1, 2'b01, 32'h100, 32'h0, 1'b1, 1'b0);
        check("ras_call_pc", bus.program_counter, 32'h140);
        check("ras_cnt1", 32'(bus.ras_count), 32'h1);
        step(1'b1, 2'b10, 32'h0, 32'h0, 1'b0, 1'b1);
        check("ras_ret_pc", bus.program_counter, 32'h44);
        check("ras_cnt0", 32'(bus.ras_count), 32'h0);

        // Five calls overflow a four-deep stack; pushes are 0x48..0x88.
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 2'b01, 32'h10, 32'h0, 1'b1, 1'b0);
        end
        check("ras_full_pc", bus.program_counter, 32'h94);
        check("ras_full_cnt", 32'(bus.ras_count), 32'h4);
        step(1'b1, 2'b10, 32'h0, 32'h0, 1'b0, 1'b1);
        check("ras_pop1", bus.program_counter, 32'h88);
        step(1'b1, 2'b10, 32'h0, 32'h0, 1'b0, 1'b1);
        check("ras_pop2", bus.program_counter, 32'h78);
        step(1'b1, 2'b10, 32'h0, 32'h0, 1'b0, 1'b1);
        check("ras_pop3", bus.program_counter, 32'h68);
        step(1'b1, 2'b10, 32'h0, 32'h0, 1'b0, 1'b1);
        check("ras_pop4", bus.program_counter, 32'h58);
        check("ras_empty", 32'(bus.ras_count), 32'h0);
        step(1'b1, 2'b10, 32'h0, 32'h80, 1'b0, 1'b1);
        check("ras_fallback", bus.program_counter, 32'h80);
        check("ras_fb_cnt", 32'(bus.ras_count), 32'h0);
`else
        // Without the stack, call/return are plain jumps.
        step(1'b1, 2'b00, 32'h0, 32'h0, 1'b1, 1'b0);
        check("noras_call_pc", bus.program_counter, 32'h8);
        check("noras_call_cnt", 32'(bus.ras_count), 32'h0);
        step(1'b1, 2'b10, 32'h0, 32'h80, 1'b0, 1'b1);
        check("noras_ret_pc", bus.program_counter, 32'h80);
        check("noras_ret_cnt", 32'(bus.ras_count), 32'h0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
